sum_window_accumulator: RTL and testbench
=========================================

# sum_window_accumulator

Downstream consumer of the 4-bit operand adder's 5-bit sum stream. Accepts one sum per valid/ready transfer, accumulates a fixed window of CNT sums, then presents the window total, sample count and overflow flag on a valid/ready output until it is taken. A `flush` pulse closes a partial window early. Sits between the adder and any reporting or display logic.

## Interface
- `IN_W`, 5, input sum width; matches the adder's 5-bit output.
- `CNT`, 8, samples per window; range 2..255.
- `ACC_W`, 8, accumulator/total width; CNT=8 with ACC_W=8 cannot overflow for 5-bit inputs.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_sum` holds a sample.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_sum`  in  IN_W  unsigned sum from the adder.
- `flush`  in  1  single-cycle request to close the current window early.
- `out_valid`  out  1  window result is available.
- `out_ready`  in  1  downstream accepts the result.
- `out_total`  out  ACC_W  accumulated window total.
- `out_count`  out  $clog2(CNT+1)  number of samples in the window.
- `out_ovf`  out  1  the window total exceeded 2^ACC_W−1.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM with acc=0, cnt=0, ovf=0.
- **ACCUM:**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: acc += zero-extended `in_sum`; cnt += 1; ovf is set if the add carries out of ACC_W bits.
  - Go to HOLD when the accepted sample makes cnt==CNT.
  - Also go to HOLD when `flush` is high and the post-update cnt ≥ 1.
- **Simultaneous `flush` and `in_valid`:** the sample is included, then the window closes.
- **`flush` with cnt==0 and no sample:** ignored; the block stays in ACCUM.
- **HOLD:**
  - `in_ready`=0, `out_valid`=1.
  - `out_total`, `out_count` and `out_ovf` are stable and register-driven.
  - `flush` and `in_valid` are ignored.
  - On `out_ready`: return to ACCUM with acc=0, cnt=0, ovf=0.
- Outputs are don't-care-free: while `out_valid`=0, `out_total`, `out_count` and `out_ovf` read 0.
- Arithmetic is unsigned. Without saturation the accumulator wraps modulo 2^ACC_W.
- **Reset mid-operation:** a partial window or pending result is discarded; no output is produced for it.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, 1 in the first cycle after; `out_valid`=0; `out_total`=0; `out_count`=0; `out_ovf`=0.
- Latency: the final sample or flush is accepted at edge t; `out_valid` rises in the cycle after t.
- Minimum window period is CNT+1 cycles: CNT accept cycles plus one HOLD cycle, with `out_ready` held high.
- `in_ready` is a combinational decode of state only; it never depends on `in_valid`.
- `out_valid`, once high, stays high until the `out_ready` handshake; output data does not change while `out_valid`=1.

## Configuration
- Macro: `SUM_WINDOW_ACC_SAT_EN`.
- **Defined:** the accumulator saturates at 2^ACC_W−1 and stays there for the rest of the window. `out_ovf` is set when saturation occurs.
- **Undefined:** the accumulator wraps modulo 2^ACC_W. `out_ovf` is set on any carry-out.
- Handshake and timing are identical in both builds.

## Structure
- Package `sum_window_pkg`:
  - state enum `{ACCUM, HOLD}`;
  - default constants `SUM_IN_W`=5, `SUM_CNT`=8, `SUM_ACC_W`=8.
- One sub-module, `sum_acc_addsat`:
  - combinational unsigned add of ACC_W + IN_W;
  - outputs the next accumulator value and a carry/overflow bit;
  - saturation logic inside it is guarded by `SUM_WINDOW_ACC_SAT_EN`.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- Reset, then eight back-to-back samples of `in_sum`=31 (CNT=8, ACC_W=8) -> `out_valid` in the cycle after the 8th accept; `out_total`=248, `out_count`=8, `out_ovf`=0.
- Samples 3, 5, 7 with `flush` asserted together with the 7 -> `out_total`=15, `out_count`=3; a `flush` pulse alone with cnt==0 -> no `out_valid`.
- `out_ready` held low for 5 cycles in HOLD -> `in_ready`=0, outputs stable, extra `in_valid` samples not consumed; `out_ready`=1 -> ACCUM with cnt=0 in the next cycle.
- ACC_W=6, eight samples of 31 -> `out_total`=56 with `out_ovf`=1 (macro undefined); `out_total`=63 with `out_ovf`=1 (macro defined).
- `rst` pulsed after 4 of 8 samples, then eight samples of 1 -> `out_total`=8, `out_count`=8; no result is emitted for the aborted window.
- Random `in_valid`/`out_ready` gaps over 100 windows -> every `out_total` matches a scoreboard sum; no sample is lost or duplicated.

Source files
------------

// File: rtl/sum_window_pkg.sv
// rtl/sum_window_pkg.sv - shared state type and default widths for the sum window accumulator
package sum_window_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int SUM_IN_W  = 5;
  localparam int SUM_CNT   = 8;
  localparam int SUM_ACC_W = 8;

endpackage

// File: rtl/sum_acc_addsat.sv
// rtl/sum_acc_addsat.sv - unsigned accumulator add with carry-out; saturation under SUM_WINDOW_ACC_SAT_EN
// Wrapping add by default; with SUM_WINDOW_ACC_SAT_EN the result clamps to all-ones on carry.
module sum_acc_addsat
  import sum_window_pkg::*;
#(
  parameter int IN_W  = SUM_IN_W,
  parameter int ACC_W = SUM_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  add,
  output logic [ACC_W-1:0] acc_next,
  output logic             ovf
);

  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + (ACC_W+1)'(add);
  assign ovf = sum[ACC_W];

`ifdef SUM_WINDOW_ACC_SAT_EN
  // Once clamped, any further non-zero add carries again, so the value stays pinned.
  assign acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_window_accumulator.sv
// rtl/sum_window_accumulator.sv - windowed sum of adder samples with valid/ready in and out
// Saturating accumulation is selected by SUM_WINDOW_ACC_SAT_EN (wrapping when undefined).
module sum_window_accumulator
  import sum_window_pkg::*;
#(
  parameter int IN_W  = SUM_IN_W,
  parameter int CNT   = SUM_CNT,
  parameter int ACC_W = SUM_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_sum,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_total,
  output logic [$clog2(CNT+1)-1:0]   out_count,
  output logic                       out_ovf
);

  localparam int CNT_W = $clog2(CNT+1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   tot_q, tot_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic               rovf_q, rovf_d;

  logic [ACC_W-1:0]   add_next;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_upd;
  logic [CNT_W-1:0]   cnt_upd;
  logic               ovf_upd;
  logic               close;

  sum_acc_addsat #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_addsat (
    .acc      (acc_q),
    .add      (in_sum),
    .acc_next (add_next),
    .ovf      (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tot_d   = tot_q;
    rcnt_d  = rcnt_q;
    rovf_d  = rovf_q;
    acc_upd = acc_q;
    cnt_upd = cnt_q;
    ovf_upd = ovf_q;
    close   = 1'b0;

    if (in_valid) begin
      acc_upd = add_next;
      cnt_upd = cnt_q + CNT_W'(1);
      ovf_upd = ovf_q | add_ovf;
    end

    case (state_q)
      ACCUM: begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
        // A flush that arrives with the sample includes that sample in the closing window.
        close = (in_valid && (cnt_upd == CNT_W'(CNT))) || (flush && (cnt_upd != '0));
        if (close) begin
          state_d = HOLD;
          tot_d   = acc_upd;
          rcnt_d  = cnt_upd;
          rovf_d  = ovf_upd;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          tot_d   = '0;
          rcnt_d  = '0;
          rovf_d  = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tot_q   <= '0;
      rcnt_q  <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tot_q   <= tot_d;
      rcnt_q  <= rcnt_d;
      rovf_q  <= rovf_d;
    end
  end

  // Result registers are zero outside HOLD, so the outputs need no gating by out_valid.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_total = tot_q;
  assign out_count = rcnt_q;
  assign out_ovf   = rovf_q;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// tb/tb_sum_window_accumulator.sv - directed and randomized checks of sum_window_accumulator
module tb_sum_window_accumulator;

  localparam int IN_W = 5;
  localparam int CNT  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, flush, out_ready;
  logic [4:0] in_sum;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_total;
  logic [3:0] out_count;

  logic       in_valid6, flush6, out_ready6;
  logic [4:0] in_sum6;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_total6;
  logic [3:0] out_count6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_window_accumulator #(.IN_W(IN_W), .CNT(CNT), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_count(out_count), .out_ovf(out_ovf)
  );

  sum_window_accumulator #(.IN_W(IN_W), .CNT(CNT), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .in_sum(in_sum6),
    .flush(flush6), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_total(out_total6), .out_count(out_count6), .out_ovf(out_ovf6)
  );

  function automatic int exp_total(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef SUM_WINDOW_ACC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s % (1 << w);
`endif
  endfunction

  function automatic int exp_ovf(input int s, input int w);
    return (s > ((1 << w) - 1)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit f);
    in_valid = 1'b1;
    in_sum   = 5'(v);
    flush    = f;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int s, input int n);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_total"}, out_total, exp_total(s, 8));
    chk({tag, "_count"}, out_count, n);
    chk({tag, "_ovf"},   out_ovf,   exp_ovf(s, 8));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_total", out_total, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  int  n, s, v, g, d;
  bit  late;

  initial begin
    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0; in_sum = 0;
    in_valid6 = 0; flush6 = 0; out_ready6 = 0; in_sum6 = 0;
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_total", out_total, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // eight back-to-back 31s
    for (int k = 0; k < CNT; k++) begin
      chk("full_out_valid_low", out_valid, 0);
      send(31, 0);
    end
    chk_result("full31", 248, 8);
    release_result();

    // flush together with the last sample
    send(3, 0);
    send(5, 0);
    send(7, 1);
    chk_result("flush3", 15, 3);
    release_result();

    // flush alone on an empty window is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty_flush_valid", out_valid, 0);
    step();
    chk("empty_flush_valid2", out_valid, 0);
    chk("empty_flush_in_ready", in_ready, 1);

    // HOLD with back-pressure and junk input
    for (int k = 0; k < CNT; k++) send(2, 0);
    in_valid = 1'b1; in_sum = 5'd9; flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_in_ready", in_ready, 0);
      chk_result("hold", 16, 8);
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    release_result();
    send(4, 1);
    chk_result("after_hold", 4, 1);
    release_result();

    // ACC_W=6 overflow
    in_valid6 = 1'b1; in_sum6 = 5'd31;
    for (int k = 0; k < CNT; k++) begin
      chk("w6_valid_low", out_valid6, 0);
      step();
    end
    in_valid6 = 1'b0;
    chk("w6_valid", out_valid6, 1);
    chk("w6_total", out_total6, exp_total(248, 6));
    chk("w6_count", out_count6, 8);
    chk("w6_ovf", out_ovf6, 1);
    out_ready6 = 1'b1;
    step();
    out_ready6 = 1'b0;
    chk("w6_release", out_valid6, 0);

    // reset mid-window discards the partial sum
    for (int k = 0; k < 4; k++) send(20, 0);
    rst = 1'b1;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    rst = 1'b0;
    step();
    chk("midrst_in_ready_after", in_ready, 1);
    for (int k = 0; k < CNT; k++) begin
      chk("midrst_valid_low", out_valid, 0);
      send(1, 0);
    end
    chk_result("midrst", 8, 8);
    release_result();

    // randomized windows against a running sum
    for (int w = 0; w < 100; w++) begin
      n = $urandom_range(1, CNT);
      late = 1'($urandom_range(0, 1));
      s = 0;
      for (int k = 0; k < n; k++) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          chk("rnd_gap_valid", out_valid, 0);
          step();
        end
        v = $urandom_range(0, 31);
        s += v;
        chk("rnd_in_ready", in_ready, 1);
        send(v, (k == n - 1) && (n < CNT) && !late);
      end
      if (n < CNT && late) begin
        chk("rnd_late_valid_low", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sum = 5'($urandom_range(0, 31));
        chk("rnd_hold_in_ready", in_ready, 0);
        chk_result("rnd_hold", s, n);
        step();
      end
      in_valid = 1'b0;
      chk_result("rnd", s, n);
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
